chan_scan_mux: RTL
==================

CHAN_SCAN_MUX -- requirements
Module: chan_scan_mux

Interface
REQ-001 Parameter CH, default 8, number of input channels (2..16).
REQ-002 Parameter W, default 4, bits per channel.
REQ-003 Parameter DWELL, default 4, clock cycles each channel is held in scan mode (1..255).
REQ-004 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 Port rst_n  input  1  reset; synchronous, active-low.
REQ-006 Port d_in  input  CH*W  packed channels; channel k at bits [k*W +: W].
REQ-007 Port en  input  1  block enable.
REQ-008 Port mode  input  1  0 = manual select, 1 = automatic scan.
REQ-009 Port sel  input  clog2(CH)  manual channel select.
REQ-010 Port y  output  W  registered selected data.
REQ-011 Port ch_out  output  clog2(CH)  channel index that y came from.
REQ-012 Port y_valid  output  1  y/ch_out hold a legal channel's data.

Function
REQ-013 FSM states: IDLE, MANUAL, SCAN, encoded in the shared package.
REQ-014 IDLE when en=0; transitions to MANUAL (mode=0) or SCAN (mode=1) on the cycle en is sampled 1.
REQ-015 In MANUAL or SCAN, en=0 returns to IDLE next cycle; y and ch_out hold; y_valid=0.
REQ-016 MANUAL: y = channel sel, ch_out = sel, y_valid=1, one-cycle latency from sel/d_in to y.
REQ-017 MANUAL with sel >= CH (non-power-of-2 CH): y=0, ch_out=0, y_valid=0.
REQ-018 SCAN: 8-bit dwell counter counts 0..DWELL-1; the channel pointer advances on the cycle the counter is DWELL-1.
REQ-019 Channel pointer wraps from CH-1 to 0.
REQ-020 SCAN: y tracks live d_in of the current pointer channel every cycle, one-cycle latency; y_valid=1.
REQ-021 mode change while enabled takes effect next cycle; entering SCAN always restarts with pointer=0 and dwell=0.
REQ-022 MANUAL-to-SCAN and SCAN-to-MANUAL switches pass through no IDLE cycle.
REQ-023 DWELL=1: pointer advances every cycle.

Reset
REQ-024 rst_n=0 at a clock edge forces state=IDLE, y=0, ch_out=0, y_valid=0, pointer=0, dwell=0, regardless of en/mode.
REQ-025 Reset asserted mid-scan aborts the scan; after release, scan restarts at channel 0.

Configuration
REQ-026 Macro CHAN_SCAN_MUX_PARITY_EN defined: extra output y_par (1 bit) is registered even parity of the next y; reset value 0; valid whenever y_valid is valid.
REQ-027 Macro not defined: y_par is absent and no parity logic is present.

Structure
REQ-028 Package chan_scan_mux_pkg holds the state enum and constants DWELL_W=8 and the max CH of 16.
REQ-029 Combinational sub-module mux_n (parameters CH, W) does the N:1 selection; chan_scan_mux instantiates it once and registers its output.

Verification
REQ-030 CH=8, W=4, rst_n=0 for 2 cycles with en=1, mode=1 -> y=0, ch_out=0, y_valid=0 throughout reset.
REQ-031 Manual: d_in channel k = k, en=1, mode=0, sel=5 -> next cycle y=5, ch_out=5, y_valid=1; sel=2 -> y=2 one cycle later.
REQ-032 Scan, DWELL=4: ch_out sequence 0,0,0,0,1,1,1,1,...,7 (x4) then 0; y equals ch_out value each cycle.
REQ-033 CH=6, manual sel=7 -> y=0, y_valid=0; sel=5 -> y=5, y_valid=1.
REQ-034 Scan at channel 3, drive mode=0 with sel=1 and then mode=1 -> y=1 in MANUAL, then scan restarts at ch_out=0.
REQ-035 With CHAN_SCAN_MUX_PARITY_EN, manual sel of a channel holding 4'b0111 -> y_par=1; channel holding 4'b0110 -> y_par=0.

Source files
------------

// File: rtl/chan_scan_mux_pkg.sv
// Shared types and constants for the channel scan multiplexer.
package chan_scan_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MANUAL,
    ST_SCAN
  } state_t;

  localparam int DWELL_W = 8;
  localparam int MAX_CH  = 16;

endpackage

// File: rtl/chan_scan_mux_mux_n.sv
// Combinational N:1 channel selector; an out-of-range select yields zero data and hit=0.
module mux_n #(
  parameter int CH = 8,
  parameter int W  = 4
) (
  input  logic [CH*W-1:0]       d_in,
  input  logic [$clog2(CH)-1:0] sel,
  output logic [W-1:0]          y,
  output logic                  hit
);

  localparam int SEL_W = $clog2(CH);

  always_comb begin
    y   = '0;
    hit = 1'b0;
    for (int k = 0; k < CH; k++) begin
      if (sel == SEL_W'(k)) begin
        y   = d_in[k*W +: W];
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chan_scan_mux.sv
// Registered channel multiplexer with manual select and timed automatic scan.
// Optional y_par output (even parity of y) is built when CHAN_SCAN_MUX_PARITY_EN is defined.
module chan_scan_mux
  import chan_scan_mux_pkg::*;
#(
  parameter int CH    = 8,
  parameter int W     = 4,
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH*W-1:0]       d_in,
  input  logic                  en,
  input  logic                  mode,
  input  logic [$clog2(CH)-1:0] sel,
  output logic [W-1:0]          y,
  output logic [$clog2(CH)-1:0] ch_out,
  output logic                  y_valid
`ifdef CHAN_SCAN_MUX_PARITY_EN
  ,
  output logic                  y_par
`endif
);

  localparam int SEL_W = $clog2(CH);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]   PTR_LAST   = SEL_W'(CH - 1);

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   ptr, ptr_nxt, mux_sel;
  logic [DWELL_W-1:0] dwell, dwell_nxt;
  logic [W-1:0]       mux_y;
  logic               mux_hit;

  mux_n #(
    .CH (CH),
    .W  (W)
  ) u_mux (
    .d_in (d_in),
    .sel  (mux_sel),
    .y    (mux_y),
    .hit  (mux_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Scan position is the channel/dwell pair that will be registered at this edge;
  // any entry into SCAN (from IDLE or MANUAL) restarts it at channel 0, count 0.
  always_comb begin
    state_nxt = ST_IDLE;
    ptr_nxt   = ptr;
    dwell_nxt = dwell;
    mux_sel   = sel;
    if (en) begin
      if (!mode) begin
        state_nxt = ST_MANUAL;
      end else begin
        state_nxt = ST_SCAN;
        if (state != ST_SCAN) begin
          ptr_nxt   = '0;
          dwell_nxt = '0;
        end else if (dwell == DWELL_LAST) begin
          dwell_nxt = '0;
          ptr_nxt   = (ptr == PTR_LAST) ? '0 : ptr + SEL_W'(1);
        end else begin
          dwell_nxt = dwell + DWELL_W'(1);
        end
        mux_sel = ptr_nxt;
      end
    end
  end

  // Output register: data holds while disabled, only the valid flag drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr     <= '0;
      dwell   <= '0;
      y       <= '0;
      ch_out  <= '0;
      y_valid <= 1'b0;
    end else begin
      ptr   <= ptr_nxt;
      dwell <= dwell_nxt;
      if (en) begin
        y       <= mux_y;
        ch_out  <= mux_hit ? mux_sel : '0;
        y_valid <= mux_hit;
      end else begin
        y_valid <= 1'b0;
      end
    end
  end

`ifdef CHAN_SCAN_MUX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n)  y_par <= 1'b0;
    else if (en) y_par <= ^mux_y;
  end
`endif

endmodule
